instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_pkg.sv | 15 +
 rtl/instr_pack.sv | 27 ++
 rtl/instr_encoder.sv | 141 ++++++++++++++
 tb/tb_instr_encoder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared definitions for the instruction encoder: format codes and major opcodes.
package instr_pkg;

  typedef enum logic [1:0] {
    FMT_LOAD  = 2'd0,
    FMT_STORE = 2'd1,
    FMT_R     = 2'd2,
    FMT_RSVD  = 2'd3
  } fmt_e;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: builds a 32-bit instruction word from its fields.
// The reserved format packs to zero; the caller drops it before it is stored.
module instr_pack
  import instr_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [11:0] imm,
  output logic [31:0] instr
);

  // Select the bit layout for the requested format.
  always_comb begin
    instr = '0;
    case (fmt)
      FMT_LOAD:  instr = {imm, rs1, funct3, rd, OPC_LOAD};
      FMT_STORE: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      FMT_R:     instr = {funct7, rs2, rs1, funct3, rd, OPC_OP};
      default:   instr = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts field requests, packs them into 32-bit words and
// queues them in a two-entry buffer with a running word address.
// Optional feature: define INSTR_ENCODER_RANGE_CHECK_EN to drop load/store requests
// whose immediate does not fit in 12 signed bits (flagged on err_range).
module instr_encoder
  import instr_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [63:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_fmt,
  output logic              err_range
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [1:0]        FullCnt  = 2'(DEPTH);

  fmt_e              fmt;
  logic [31:0]       packed_word;
  logic              accept, drop, push, pop, range_bad;

  logic [31:0]       mem_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_fmt_q, err_fmt_d;

  assign fmt = fmt_e'(in_fmt);

  instr_pack u_pack (
    .fmt    (fmt),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm[11:0]),
    .instr  (packed_word)
  );

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  logic imm_fits;
  logic err_range_q, err_range_d;

  // Fits in 12 signed bits when bits 63..11 are all copies of the sign.
  assign imm_fits  = (in_imm[63:11] == '0) || (in_imm[63:11] == '1);
  assign range_bad = ((fmt == FMT_LOAD) || (fmt == FMT_STORE)) && !imm_fits;

  // Sticky range flag, cleared only by in_clr or reset.
  always_comb begin
    err_range_d = err_range_q | (accept & range_bad);
    if (in_clr) err_range_d = 1'b0;
  end

  // Range flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_range_q <= 1'b0;
    else        err_range_q <= err_range_d;
  end

  assign err_range = err_range_q;
`else
  // Upper immediate bits are simply truncated away in this build.
  logic unused_imm;
  assign unused_imm = ^in_imm[63:12];
  assign range_bad  = 1'b0;
  assign err_range  = 1'b0;
`endif

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;
  // A request that coincides with a clear is treated as never accepted.
  assign accept    = in_valid & ready_q & ~in_clr;
  assign drop      = (fmt == FMT_RSVD) | range_bad;
  assign push      = accept & ~drop;

  // Next-state for buffer pointers, occupancy, address counter and format flag.
  always_comb begin
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
    count_d   = count_q + {1'b0, push} - {1'b0, pop};
    addr_d    = pop ? addr_q + ADDR_W'(4) : addr_q;
    err_fmt_d = err_fmt_q | (accept & (fmt == FMT_RSVD));
    if (in_clr) begin
      wr_ptr_d  = 1'b0;
      rd_ptr_d  = 1'b0;
      count_d   = 2'd0;
      addr_d    = BaseAddr;
      err_fmt_d = 1'b0;
    end
    // Registered ready: reflects next-cycle fullness, never out_ready directly.
    ready_d = (count_d != FullCnt);
  end

  // Buffer storage and control state, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      ready_q   <= 1'b0;
      addr_q    <= BaseAddr;
      err_fmt_q <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= packed_word;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      addr_q    <= addr_d;
      err_fmt_q <= err_fmt_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_instr = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_addr  = addr_q;
  assign err_fmt   = err_fmt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (ADDR_W=4, BASE_ADDR=12 to exercise wrap).
module tb_instr_encoder;

  localparam int AW   = 4;
  localparam int BASE = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_fmt = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [63:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          err_fmt, err_range;

  int checks = 0;
  int failures = 0;

  // Behavioural model state.
  logic [31:0] mq[$];
  int          maddr = BASE;
  bit          mready = 0, mefmt = 0, merng = 0;

  // Observed output handshakes.
  logic [31:0] log_instr[$];
  int          log_addr[$];

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_clr    (in_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err_fmt   (err_fmt),
    .err_range (err_range)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding with plain arithmetic on the field values.
  function automatic logic [31:0] enc(input int fmt, input int rd, input int rs1, input int rs2,
                                     input int f3, input int f7, input longint imm);
    longint unsigned lo, w;
    lo = longint'(imm) & 64'hFFF;
    case (fmt)
      0: w = lo * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * 128 + 3;
      1: w = (lo / 32) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12)
             + (lo % 32) * 128 + 35;
      2: w = f7 * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * 128 + 51;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  // Model update on each clock edge (or immediately on reset).
  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      maddr  = BASE;
      mready = 0;
      mefmt  = 0;
      merng  = 0;
    end else begin
      bit acc, bad;
      acc = in_valid && mready && !in_clr;
      if (in_clr) begin
        mq.delete();
        maddr = BASE;
        mefmt = 0;
        merng = 0;
      end else begin
        if (mq.size() > 0 && out_ready) begin
          void'(mq.pop_front());
          maddr = (maddr + 4) % 16;
        end
        if (acc) begin
          bad = 0;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
          if (in_fmt < 2 && ($signed(in_imm) < -2048 || $signed(in_imm) > 2047)) bad = 1;
`endif
          if (in_fmt == 3) mefmt = 1;
          else if (bad) merng = 1;
          else mq.push_back(enc(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm));
        end
      end
      mready = (mq.size() < 2);
    end
  end

  // Compare process: every falling edge, DUT versus model (or reset values).
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_instr", out_instr, 0);
      check("rst_out_addr", out_addr, BASE);
      check("rst_err_fmt", err_fmt, 0);
      check("rst_err_range", err_range, 0);
    end else begin
      check("cmp_out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) check("cmp_out_instr", out_instr, mq[0]);
      check("cmp_in_ready", in_ready, mready);
      check("cmp_out_addr", out_addr, maddr);
      check("cmp_err_fmt", err_fmt, mefmt);
      check("cmp_err_range", err_range, merng);
      if (out_valid && out_ready) begin
        log_instr.push_back(out_instr);
        log_addr.push_back(int'(out_addr));
      end
    end
  end

  task automatic drive(input int fmt, input int rd, input int rs1, input int rs2,
                       input int f3, input int f7, input longint imm);
    in_valid  = 1'b1;
    in_fmt    = 2'(fmt);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_funct3 = 3'(f3);
    in_funct7 = 7'(f7);
    in_imm    = 64'(imm);
  endtask

  // Wait until the request is taken; bounded so a stuck in_ready cannot hang the run.
  task automatic wait_accept(input string name);
    bit r;
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 50) begin
        check({name, "_accept_timeout"}, 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input string name, input int fmt, input int rd, input int rs1,
                      input int rs2, input int f3, input int f7, input longint imm);
    drive(fmt, rd, rs1, rs2, f3, f7, imm);
    wait_accept(name);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int base_n;
    cycles(3);
    check("reset_in_ready_low", in_ready, 0);
    check("reset_addr", out_addr, 12);
    rst_n = 1'b1;
    cycles(1);
    check("ready_after_reset", in_ready, 1);

    // Single load, one-cycle latency.
    out_ready = 1'b1;
    drive(0, 5, 2, 0, 3, 0, 8);
    wait_accept("load");
    @(negedge clk);
    check("load_valid", out_valid, 1);
    check("load_word", out_instr, 32'h00813283);
    check("load_addr", out_addr, 12);
    cycles(1);

    // Store then R-type back to back; addresses wrap 12 -> 0 -> 4.
    send("store", 1, 0, 2, 5, 3, 0, 16);
    send("rtype", 2, 3, 1, 2, 0, 0, 0);
    send("load_neg", 0, 1, 1, 0, 3, 0, -1);
    cycles(3);
    check("log_size_4", log_instr.size(), 4);
    if (log_instr.size() >= 4) begin
      check("log0_addr", log_addr[0], 12);
      check("log1_word", log_instr[1], 32'h00513823);
      check("log1_addr_wrap", log_addr[1], 0);
      check("log2_word", log_instr[2], 32'h002081B3);
      check("log2_addr", log_addr[2], 4);
      check("log3_word", log_instr[3], 32'hFFF0B083);
    end
    check("neg_err_range", err_range, 0);

    // Out-of-range immediate.
    base_n = log_instr.size();
    send("imm4096", 0, 1, 1, 0, 3, 0, 4096);
    cycles(3);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    check("range_no_output", log_instr.size(), base_n);
    check("range_err_set", err_range, 1);
`else
    check("trunc_output", log_instr.size(), base_n + 1);
    if (log_instr.size() > base_n) check("trunc_word", log_instr[base_n], 32'h0000B083);
    check("trunc_err_zero", err_range, 0);
`endif

    // Backpressure: two fill the buffer, third waits.
    out_ready = 1'b0;
    base_n = log_instr.size();
    send("bp0", 0, 1, 0, 0, 2, 0, 1);
    send("bp1", 0, 1, 0, 0, 2, 0, 2);
    drive(0, 1, 0, 0, 2, 0, 3);
    repeat (3) begin
      @(negedge clk);
      check("bp_ready_low", in_ready, 0);
      check("bp_hold_word", out_instr, 32'h00102083);
    end
    out_ready = 1'b1;
    wait_accept("bp2");
    cycles(4);
    check("bp_count", log_instr.size(), base_n + 3);
    if (log_instr.size() >= base_n + 3) begin
      check("bp_w0", log_instr[base_n], 32'h00102083);
      check("bp_w1", log_instr[base_n + 1], 32'h00202083);
      check("bp_w2", log_instr[base_n + 2], 32'h00302083);
    end

    // Reserved format: dropped, sticky flag until clear.
    base_n = log_instr.size();
    send("rsvd", 3, 1, 1, 1, 0, 0, 0);
    cycles(4);
    check("rsvd_no_output", log_instr.size(), base_n);
    check("rsvd_err_sticky", err_fmt, 1);
    drive(0, 5, 2, 0, 3, 0, 8);
    in_clr = 1'b1;
    cycles(1);
    in_clr   = 1'b0;
    in_valid = 1'b0;
    cycles(2);
    check("clr_err_fmt", err_fmt, 0);
    check("clr_discard", log_instr.size(), base_n);
    check("clr_addr", out_addr, 12);

    // Reset with two words buffered.
    out_ready = 1'b0;
    send("rst0", 0, 2, 0, 0, 0, 0, 5);
    send("rst1", 0, 3, 0, 0, 0, 0, 6);
    @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    base_n = log_instr.size();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_valid_now", out_valid, 0);
    cycles(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycles(5);
    check("post_rst_no_stale", log_instr.size(), base_n);
    check("post_rst_addr", out_addr, 12);
    check("post_rst_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
